// File: rtl/dino_score_if.sv
// Dino score sequencer bus: game-control requests in, score/status out.
// The master side (game top / testbench) drives the requests and the
// slave side (dino_score_ctrl) drives the score and status.
interface dino_score_if;
  logic        i_start;
  logic        i_hit;
  logic        i_pause;
  logic [15:0] o_score;
  logic [15:0] o_hiscore;
  logic [1:0]  o_state;
  logic        o_running;
  logic        o_speedup;
  logic [2:0]  o_level;
  logic        o_new_hi;

  modport master (
    output i_start, i_hit, i_pause,
    input  o_score, o_hiscore, o_state, o_running, o_speedup, o_level, o_new_hi
  );

  modport slave (
    input  i_start, i_hit, i_pause,
    output o_score, o_hiscore, o_state, o_running, o_speedup, o_level, o_new_hi
  );
endinterface

// File: rtl/dino_score_ctrl.sv
// Dino game score sequencer: idle/run/pause/over state machine, score tick
// divider, 4-digit packed-BCD score with saturation at 9999, high-score
// tracking and a speed-up pulse on every hundreds-boundary crossing.
module dino_score_ctrl #(
  parameter int TICK_DIV  = 5000000,
  parameter int LEVEL_MAX = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  dino_score_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_TERM = TW'(TICK_DIV - 1);
  localparam logic [2:0]    LVL_MAX   = 3'(LEVEL_MAX);
  localparam logic [15:0]   SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Packed-BCD +1: each nibble wraps 9->0 and ripples its carry upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [15:0]   score_q;
  logic [15:0]   hiscore_q;
  logic [2:0]    level_q;
  logic          speedup_q;
  logic          new_hi_q;
  logic          running_q;

  logic [15:0]   score_d;
  logic          cross_d;
  logic [2:0]    level_d;

  // Next score on a tick, whether it crosses a hundreds boundary, and the
  // saturating level that goes with such a crossing.
  always_comb begin
    score_d = score_q;
    cross_d = 1'b0;
    level_d = level_q;
    if (score_q != SCORE_MAX) begin
      score_d = bcd_inc(score_q);
      cross_d = (score_q[7:0] == 8'h99);
    end else begin
      score_d = score_q;
      cross_d = 1'b0;
    end
    if (level_q < LVL_MAX) begin
      level_d = level_q + 3'd1;
    end else begin
      level_d = level_q;
    end
  end

  // Game state machine with tick divider, score, high score and status registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      score_q   <= 16'h0000;
      hiscore_q <= 16'h0000;
      level_q   <= 3'd0;
      speedup_q <= 1'b0;
      new_hi_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      speedup_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          // Start wins over a simultaneous hit; hit is only looked at in RUN.
          if (bus.i_start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            score_q   <= 16'h0000;
            level_q   <= 3'd0;
            tick_q    <= '0;
            new_hi_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.i_hit) begin
            state_q   <= ST_OVER;
            running_q <= 1'b0;
            if (score_q > hiscore_q) begin
              hiscore_q <= score_q;
              new_hi_q  <= 1'b1;
            end
          end else if (bus.i_pause) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (tick_q == TICK_TERM) begin
            tick_q  <= '0;
            score_q <= score_d;
            if (cross_d) begin
              speedup_q <= 1'b1;
              level_q   <= level_d;
            end
          end else begin
            tick_q <= tick_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        ST_PAUSE: begin
          // Resume with the held tick count.
          if (!bus.i_pause) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_score   = score_q;
  assign bus.o_hiscore = hiscore_q;
  assign bus.o_state   = state_q;
  assign bus.o_running = running_q;
  assign bus.o_speedup = speedup_q;
  assign bus.o_level   = level_q;
  assign bus.o_new_hi  = new_hi_q;

endmodule

// File: tb/tb_dino_score_ctrl.sv
// Directed testbench for dino_score_ctrl: one instance with TICK_DIV=4 and
// one with TICK_DIV=2. Inputs change and outputs are sampled on the falling edge.
module tb_dino_score_ctrl;

  logic clk;
  logic rst4;
  logic rst2;
  int   total;
  int   bad;

  dino_score_if if4 ();
  dino_score_if if2 ();

  dino_score_ctrl #(.TICK_DIV(4), .LEVEL_MAX(7)) dut4 (
    .i_clk (clk),
    .i_rst (rst4),
    .bus   (if4)
  );

  dino_score_ctrl #(.TICK_DIV(2), .LEVEL_MAX(7)) dut2 (
    .i_clk (clk),
    .i_rst (rst2),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer 0..9999 to packed BCD.
  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'((n)        % 10);
    r[7:4]   = 4'((n / 10)   % 10);
    r[11:8]  = 4'((n / 100)  % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start4();
    if4.i_start = 1'b1;
    step();
    if4.i_start = 1'b0;
  endtask

  task automatic start2();
    if2.i_start = 1'b1;
    step();
    if2.i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst2 = 1'b1;
    step(); step();
    total++; if (if4.o_state !== 2'd0 || if2.o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0", if4.o_state, if2.o_state); end
    total++; if (if4.o_score !== 16'h0 || if4.o_hiscore !== 16'h0) begin bad++; $display("FAIL reset_score got=%h/%h exp=0", if4.o_score, if4.o_hiscore); end
    total++; if (if4.o_level !== 3'd0 || if4.o_speedup !== 1'b0 || if4.o_new_hi !== 1'b0 || if4.o_running !== 1'b0) begin bad++; $display("FAIL reset_flags lvl=%0d sp=%b nh=%b run=%b exp=0", if4.o_level, if4.o_speedup, if4.o_new_hi, if4.o_running); end
    rst4 = 1'b0; rst2 = 1'b0;
    if4.i_hit = 1'b1; if4.i_pause = 1'b1;
    step(); step();
    total++; if (if4.o_state !== 2'd0 || if4.o_running !== 1'b0) begin bad++; $display("FAIL idle_ignores_hit_pause got state=%0d run=%b exp=0/0", if4.o_state, if4.o_running); end
    if4.i_hit = 1'b0; if4.i_pause = 1'b0;
  endtask

  task automatic test_count();
    rst4 = 1'b1; step(); rst4 = 1'b0;
    start4();
    for (int k = 1; k <= 40; k++) begin
      step();
      total++; if (if4.o_score !== to_bcd(k / 4) || if4.o_speedup !== 1'b0 || if4.o_state !== 2'd1) begin
        bad++; $display("FAIL count k=%0d got score=%h sp=%b st=%0d exp score=%h sp=0 st=1", k, if4.o_score, if4.o_speedup, if4.o_state, to_bcd(k / 4));
      end
    end
    total++; if (if4.o_score !== 16'h0010 || if4.o_running !== 1'b1) begin bad++; $display("FAIL count_final got=%h run=%b exp=0010/1", if4.o_score, if4.o_running); end
  endtask

  task automatic test_speedup();
    int n;
    int sp_seen;
    logic exp_sp;
    logic [2:0] exp_lv;
    sp_seen = 0;
    rst2 = 1'b1; step(); rst2 = 1'b0;
    start2();
    for (int k = 1; k <= 1800; k++) begin
      step();
      n      = k / 2;
      exp_sp = ((k % 2) == 0) && ((n % 100) == 0);
      exp_lv = (n / 100 > 7) ? 3'd7 : 3'(n / 100);
      if (if2.o_speedup === 1'b1) sp_seen++;
      total++; if (if2.o_score !== to_bcd(n) || if2.o_speedup !== exp_sp || if2.o_level !== exp_lv) begin
        bad++; $display("FAIL speedup k=%0d got score=%h sp=%b lvl=%0d exp score=%h sp=%b lvl=%0d", k, if2.o_score, if2.o_speedup, if2.o_level, to_bcd(n), exp_sp, exp_lv);
      end
    end
    total++; if (sp_seen !== 9) begin bad++; $display("FAIL speedup_count got=%0d exp=9", sp_seen); end
    total++; if (if2.o_score !== 16'h0900 || if2.o_level !== 3'd7) begin bad++; $display("FAIL speedup_sat got=%h lvl=%0d exp=0900/7", if2.o_score, if2.o_level); end
  endtask

  task automatic test_pause();
    rst4 = 1'b1; step(); rst4 = 1'b0;
    start4();
    step(); step();
    if4.i_pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (if4.o_state !== 2'd2 || if4.o_score !== 16'h0000 || if4.o_running !== 1'b0) begin
        bad++; $display("FAIL pause_hold k=%0d got st=%0d score=%h run=%b exp 2/0000/0", k, if4.o_state, if4.o_score, if4.o_running);
      end
    end
    if4.i_pause = 1'b0;
    step();
    total++; if (if4.o_state !== 2'd1 || if4.o_score !== 16'h0000) begin bad++; $display("FAIL pause_resume got st=%0d score=%h exp 1/0000", if4.o_state, if4.o_score); end
    step();
    total++; if (if4.o_score !== 16'h0000) begin bad++; $display("FAIL pause_early got=%h exp=0000", if4.o_score); end
    step();
    total++; if (if4.o_score !== 16'h0001) begin bad++; $display("FAIL pause_next_inc got=%h exp=0001", if4.o_score); end
  endtask

  task automatic test_hit_terminal();
    rst4 = 1'b1; step(); rst4 = 1'b0;
    start4();
    repeat (171) step();
    total++; if (if4.o_score !== 16'h0042) begin bad++; $display("FAIL hit_pre got=%h exp=0042", if4.o_score); end
    if4.i_hit = 1'b1;
    step();
    total++; if (if4.o_state !== 2'd3 || if4.o_score !== 16'h0042 || if4.o_running !== 1'b0) begin bad++; $display("FAIL hit_over got st=%0d score=%h run=%b exp 3/0042/0", if4.o_state, if4.o_score, if4.o_running); end
    total++; if (if4.o_hiscore !== 16'h0042 || if4.o_new_hi !== 1'b1) begin bad++; $display("FAIL hit_newhi got hi=%h nh=%b exp 0042/1", if4.o_hiscore, if4.o_new_hi); end
    repeat (4) step();
    total++; if (if4.o_state !== 2'd3 || if4.o_score !== 16'h0042) begin bad++; $display("FAIL over_frozen got st=%0d score=%h exp 3/0042", if4.o_state, if4.o_score); end
    if4.i_start = 1'b1;
    step();
    if4.i_start = 1'b0; if4.i_hit = 1'b0;
    total++; if (if4.o_state !== 2'd1 || if4.o_score !== 16'h0000 || if4.o_new_hi !== 1'b0) begin bad++; $display("FAIL restart got st=%0d score=%h nh=%b exp 1/0000/0", if4.o_state, if4.o_score, if4.o_new_hi); end
    repeat (120) step();
    total++; if (if4.o_score !== 16'h0030) begin bad++; $display("FAIL run2 got=%h exp=0030", if4.o_score); end
    if4.i_hit = 1'b1;
    step();
    if4.i_hit = 1'b0;
    total++; if (if4.o_state !== 2'd3 || if4.o_hiscore !== 16'h0042 || if4.o_new_hi !== 1'b0 || if4.o_score !== 16'h0030) begin
      bad++; $display("FAIL lower_run got st=%0d hi=%h nh=%b score=%h exp 3/0042/0/0030", if4.o_state, if4.o_hiscore, if4.o_new_hi, if4.o_score);
    end
  endtask

  task automatic test_reset_midrun();
    start4();
    repeat (492) step();
    total++; if (if4.o_score !== 16'h0123 || if4.o_hiscore !== 16'h0042 || if4.o_level !== 3'd1) begin bad++; $display("FAIL midrun_pre got score=%h hi=%h lvl=%0d exp 0123/0042/1", if4.o_score, if4.o_hiscore, if4.o_level); end
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    total++; if (if4.o_state !== 2'd0 || if4.o_score !== 16'h0 || if4.o_hiscore !== 16'h0 || if4.o_level !== 3'd0 || if4.o_speedup !== 1'b0 || if4.o_running !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got st=%0d score=%h hi=%h lvl=%0d sp=%b run=%b exp all 0", if4.o_state, if4.o_score, if4.o_hiscore, if4.o_level, if4.o_speedup, if4.o_running);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_s;
    rst2 = 1'b1; step(); rst2 = 1'b0;
    start2();
    repeat (19996) step();
    total++; if (if2.o_score !== 16'h9998 || if2.o_level !== 3'd7) begin bad++; $display("FAIL sat_pre got=%h lvl=%0d exp 9998/7", if2.o_score, if2.o_level); end
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_s = (k >= 2) ? 16'h9999 : 16'h9998;
      total++; if (if2.o_score !== exp_s || if2.o_speedup !== 1'b0 || if2.o_state !== 2'd1) begin
        bad++; $display("FAIL sat k=%0d got score=%h sp=%b st=%0d exp %h/0/1", k, if2.o_score, if2.o_speedup, if2.o_state, exp_s);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst4 = 1'b1; rst2 = 1'b1;
    if4.i_start = 1'b0; if4.i_hit = 1'b0; if4.i_pause = 1'b0;
    if2.i_start = 1'b0; if2.i_hit = 1'b0; if2.i_pause = 1'b0;
    test_reset();
    test_count();
    test_speedup();
    test_pause();
    test_hit_terminal();
    test_reset_midrun();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dino_score_ctrl.md
Name: dino_score_ctrl

Overview:
Game-score sequencer for the Dino game. Runs the game state machine (idle/run/pause/over) and divides i_clk into score ticks. Drives a 4-digit BCD score, as a cascade of per-digit mod-10 counters with carry ripple. Tracks the high score, and issues speed-up events every 100 points for the obstacle/scroll logic.

Parameters:
TICK_DIV, 5000000, i_clk cycles per score point while running (>=2)
LEVEL_MAX, 7, saturation value of o_level (<=7)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start/restart request, 1-cycle pulse (level tolerated)
i_hit  in  1  collision from sprite logic, sampled every cycle
i_pause  in  1  pause level
o_score  out  16  BCD score, [15:12]=thousands .. [3:0]=units
o_hiscore  out  16  BCD high score
o_state  out  2  0=IDLE 1=RUN 2=PAUSE 3=OVER
o_running  out  1  high iff state==RUN
o_speedup  out  1  1-cycle pulse on each hundreds-boundary crossing
o_level  out  3  speed level, incremented by each o_speedup
o_new_hi  out  1  high in OVER when the last run set a new high score

Behaviour:
- Reset: all of the following are forced on the clock edge while i_rst=1, overriding all other inputs:
  - state=IDLE
  - o_score, o_hiscore, o_level, tick counter = 0
  - o_speedup, o_new_hi = 0
- Tick counter: width ceil(log2(TICK_DIV)). Counts 0..TICK_DIV-1 only in RUN; held in PAUSE; cleared on every entry to RUN from IDLE/OVER.
- IDLE:
  - i_start=1 -> RUN. Same edge clears o_score, o_level, tick counter, o_new_hi.
  - i_hit and i_pause are ignored.
- RUN, per edge, priority i_hit > i_pause > tick:
  - i_hit=1 -> OVER. No score increment that edge, even if the tick counter is at terminal.
  - else i_pause=1 -> PAUSE. Tick counter and score held.
  - else if tick counter == TICK_DIV-1 -> tick counter <= 0 and score += 1 (BCD), same edge. Otherwise tick counter += 1.
  - i_start is ignored.
- BCD increment:
  - Units increment. A digit at 9 wraps to 0 and carries into the next digit, rippling combinationally within one cycle.
  - Score 9999 saturates: no increment, no wrap, no o_speedup.
- o_speedup:
  - Asserted for exactly the cycle after the edge whose increment changes tens/units from 99 to 00 (i.e., registered, aligned with the new o_score value).
  - Same edge o_level += 1, saturating at LEVEL_MAX. o_speedup still pulses when o_level is saturated.
- PAUSE:
  - i_pause=0 -> RUN, resuming the held tick count (no clear).
  - i_hit and i_start are ignored.
- OVER entry edge: if o_score > o_hiscore (plain 16-bit compare, valid for packed BCD), then o_hiscore <= o_score and o_new_hi <= 1.
- OVER:
  - o_score is frozen.
  - i_start=1 -> RUN with the same clears as from IDLE; o_new_hi -> 0.
  - i_hit is ignored.
- o_running and o_state are registered state decodes, with no combinational path from inputs.
- o_hiscore persists across runs and is cleared only by i_rst.
- i_start and i_hit asserted together in IDLE/OVER: start wins. i_hit is only evaluated in RUN, so there is no hit on the first RUN cycle unless i_hit is still high the next cycle.
- Reset mid-run: the next edge returns to IDLE with all values zeroed, the high score included.

Test Plan:
1. TICK_DIV=4; reset, pulse i_start, run 40 cycles.
   Required: o_state=1; o_score increments once every 4 cycles, so 0x0010 after 40 cycles; o_speedup never asserted.
2. TICK_DIV=2; run until o_score=0x0099, then one more tick.
   Required: o_score=0x0100, o_speedup high exactly 1 cycle, o_level=1. Continue to 0x0800: o_level=7, saturated. At 0x0900: o_speedup still pulses and o_level stays 7.
3. TICK_DIV=4; assert i_pause for 10 cycles at tick count 2, then release.
   Required: o_state=2 and o_score constant during the pause; the next increment occurs 2 cycles after return to RUN.
4. i_hit on the same cycle the tick counter hits terminal at o_score=0x0042.
   Required: o_state=3, o_score stays 0x0042, o_hiscore=0x0042, o_new_hi=1. Then i_start, run to 0x0030, hit. Required: o_hiscore stays 0x0042, o_new_hi=0.
5. Force the score to 0x9998 via long run (TICK_DIV=2), then 3 more ticks.
   Required: o_score saturates at 0x9999, no wrap, no o_speedup.
6. Assert i_rst during RUN with o_score=0x0123 and o_hiscore nonzero.
   Required after the edge: o_state=0, o_score=0, o_hiscore=0, o_level=0, o_speedup=0.
